// File: rtl/div_seq.sv
// div_seq: restoring shift-subtract divider producing one quotient bit per clock.
// Signed operation (sign correction, abs/negate logic) is built only when DIV_SIGNED_EN is defined.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               accept, last_step, zero_div;

  logic [2*WIDTH-1:0] work_p0;
  logic [WIDTH-1:0]   dvs_p0;
  logic [WIDTH-1:0]   a_mag, b_mag, q_fin, r_fin;
  logic [WIDTH:0]     up_ext;
  logic [WIDTH-1:0]   up_sub;
  logic               ge;
  logic [2*WIDTH-1:0] work_step;

`ifdef DIV_SIGNED_EN
  logic neg_q_p0, neg_r_p0;
  logic a_neg, b_neg;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign a_neg = sgn & dividend[WIDTH-1];
  assign b_neg = sgn & divisor[WIDTH-1];
  assign a_mag = cond_neg(dividend, a_neg);
  assign b_mag = cond_neg(divisor, b_neg);
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign q_fin = cond_neg(work_step[WIDTH-1:0], neg_q_p0);
  assign r_fin = cond_neg(work_step[2*WIDTH-1:WIDTH], neg_r_p0);

  always_ff @(posedge clk) begin
    if (accept) begin
      neg_q_p0 <= a_neg ^ b_neg;
      neg_r_p0 <= a_neg;
    end
  end
`else
  logic sgn_unused;
  assign sgn_unused = sgn;
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fin = work_step[WIDTH-1:0];
  assign r_fin = work_step[2*WIDTH-1:WIDTH];
`endif

  assign zero_div  = (divisor == '0);
  assign last_step = (cnt == LAST_STEP);
  assign busy      = (state == CALC);
  assign done      = (state == DONE);

  // Upper half is kept one bit wider so the shifted-out MSB still takes part in the compare.
  assign up_ext    = work_p0[2*WIDTH-1:WIDTH-1];
  assign ge        = (up_ext >= {1'b0, dvs_p0});
  assign up_sub    = up_ext[WIDTH-1:0] - dvs_p0;
  assign work_step = {(ge ? up_sub : up_ext[WIDTH-1:0]), work_p0[WIDTH-2:0], ge};

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          accept    = 1'b1;
          state_nxt = zero_div ? DONE : CALC;
        end
      end
      CALC:    if (last_step) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)             cnt <= '0;
      else if (state == CALC) cnt <= cnt + 1'b1;
    end
  end

  // ---- stage p0: working registers ----
  always_ff @(posedge clk) begin
    if (accept) begin
      work_p0 <= {{WIDTH{1'b0}}, a_mag};
      dvs_p0  <= b_mag;
    end else if (state == CALC) begin
      work_p0 <= work_step;
    end
  end

  // ---- result registers, written only on the edge that raises done ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept && zero_div) begin
      quotient  <= '1;
      remainder <= dividend;
      div_zero  <= 1'b1;
    end else if (state == CALC && last_step) begin
      quotient  <= q_fin;
      remainder <= r_fin;
      div_zero  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq at WIDTH 8, 32 and 64 against a plain-arithmetic reference model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sgn = 1'b0;
  logic [63:0] a_in = '0, b_in = '0;
  logic        st8 = 1'b0, st32 = 1'b0, st64 = 1'b0;
  logic        bz8, dn8, dz8, bz32, dn32, dz32, bz64, dn64, dz64;
  logic [7:0]  q8, r8;
  logic [31:0] q32, r32;
  logic [63:0] q64, r64;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .sgn(sgn), .dividend(a_in[7:0]), .divisor(b_in[7:0]),
    .busy(bz8), .done(dn8), .quotient(q8), .remainder(r8), .div_zero(dz8));
  div_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(st32), .sgn(sgn), .dividend(a_in[31:0]), .divisor(b_in[31:0]),
    .busy(bz32), .done(dn32), .quotient(q32), .remainder(r32), .div_zero(dz32));
  div_seq #(.WIDTH(64)) u64 (
    .clk(clk), .rst_n(rst_n), .start(st64), .sgn(sgn), .dividend(a_in), .divisor(b_in),
    .busy(bz64), .done(dn64), .quotient(q64), .remainder(r64), .div_zero(dz64));

  function automatic logic get_busy(input int w);
    case (w)
      8:       return bz8;
      32:      return bz32;
      default: return bz64;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      8:       return dn8;
      32:      return dn32;
      default: return dn64;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      8:       st8 = v;
      32:      st32 = v;
      default: st64 = v;
    endcase
  endtask

  task automatic get_res(input int w, output logic [63:0] q, output logic [63:0] r, output logic dz);
    case (w)
      8:       begin q = {56'd0, q8};  r = {56'd0, r8};  dz = dz8;  end
      32:      begin q = {32'd0, q32}; r = {32'd0, r32}; dz = dz32; end
      default: begin q = q64;          r = r64;          dz = dz64; end
    endcase
  endtask

  // Reference: integer division on sign-extended 128-bit values, truncated back to w bits.
  function automatic void ref_div(input int w, input logic [63:0] a_raw, input logic [63:0] b_raw,
                                  input logic s, output logic [63:0] q, output logic [63:0] r,
                                  output logic dz);
    logic [63:0] m, a, b;
    logic signed [127:0] sa, sb, sq, sr;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a_raw & m;
    b = b_raw & m;
    if (b == 64'd0) begin
      q = m; r = a; dz = 1'b1;
      return;
    end
    dz = 1'b0;
    sa = $signed({64'd0, a});
    sb = $signed({64'd0, b});
    if (s && a[w-1]) sa = sa - (128'sd1 <<< w);
    if (s && b[w-1]) sb = sb - (128'sd1 <<< w);
    sq = sa / sb;
    sr = sa % sb;
    q = sq[63:0] & m;
    r = sr[63:0] & m;
  endfunction

  function automatic logic eff_sgn(input logic s);
`ifdef DIV_SIGNED_EN
    return s;
`else
    return 1'b0 & s;
`endif
  endfunction

  // Start one operation, count cycles (cycle 1 follows the accept edge) until done.
  task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b, input logic s,
                        output int cyc, output int busy_cyc, output logic ovl,
                        output logic [63:0] q, output logic [63:0] r, output logic dz);
    a_in = a; b_in = b; sgn = s;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    cyc = 1; busy_cyc = 0; ovl = 1'b0;
    while (!get_done(w) && cyc < 200) begin
      if (get_busy(w)) busy_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
    ovl = get_busy(w) & get_done(w);
    get_res(w, q, r, dz);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bz8, dn8, q8, r8, dz8} !== '0) begin
      n_bad++; $display("FAIL reset_w8 got %0h want 0", {bz8, dn8, q8, r8, dz8});
    end
    n_cmp++;
    if ({bz32, dn32, q32, r32, dz32} !== '0) begin
      n_bad++; $display("FAIL reset_w32 got %0h want 0", {bz32, dn32, q32, r32, dz32});
    end
    n_cmp++;
    if ({bz64, dn64, q64, r64, dz64} !== '0) begin
      n_bad++; $display("FAIL reset_w64 got %0h want 0", {bz64, dn64, q64, r64, dz64});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    int cyc, bc; logic ovl, dz; logic [63:0] q, r;
    run_op(32, 64'd100, 64'd7, 1'b0, cyc, bc, ovl, q, r, dz);
    n_cmp++;
    if (cyc != 33 || bc != 32 || ovl !== 1'b0) begin
      n_bad++; $display("FAIL u100_7_timing got cyc=%0d busy=%0d ovl=%0b want 33/32/0", cyc, bc, ovl);
    end
    n_cmp++;
    if (q !== 64'd14 || r !== 64'd2 || dz !== 1'b0) begin
      n_bad++; $display("FAIL u100_7_result got q=%0d r=%0d dz=%0b want 14/2/0", q, r, dz);
    end
    run_op(32, 64'hFFFF_FFFF, 64'd1, 1'b0, cyc, bc, ovl, q, r, dz);
    n_cmp++;
    if (q !== 64'hFFFF_FFFF || r !== 64'd0 || dz !== 1'b0) begin
      n_bad++; $display("FAIL umax_1 got q=%0h r=%0h dz=%0b want ffffffff/0/0", q, r, dz);
    end
  endtask

  task automatic test_div_zero();
    int cyc, bc; logic ovl, dz; logic [63:0] q, r;
    run_op(32, 64'd5, 64'd0, 1'b0, cyc, bc, ovl, q, r, dz);
    n_cmp++;
    if (cyc != 1 || bc != 0 || ovl !== 1'b0) begin
      n_bad++; $display("FAIL dz_timing got cyc=%0d busy=%0d want 1/0", cyc, bc);
    end
    n_cmp++;
    if (q !== 64'hFFFF_FFFF || r !== 64'd5 || dz !== 1'b1) begin
      n_bad++; $display("FAIL dz_result got q=%0h r=%0h dz=%0b want ffffffff/5/1", q, r, dz);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (dn32 !== 1'b0 || bz32 !== 1'b0 || q32 !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL dz_pulse got done=%0b busy=%0b q=%0h want 0/0/ffffffff", dn32, bz32, q32);
    end
  endtask

  task automatic test_signed();
    int cyc, bc; logic ovl, dz; logic [63:0] q, r;
`ifdef DIV_SIGNED_EN
    run_op(32, 64'hFFFF_FFF9, 64'd2, 1'b1, cyc, bc, ovl, q, r, dz);
    n_cmp++;
    if (q !== 64'hFFFF_FFFD || r !== 64'hFFFF_FFFF || dz !== 1'b0) begin
      n_bad++; $display("FAIL s_m7_2 got q=%0h r=%0h want fffffffd/ffffffff", q, r);
    end
    run_op(32, 64'd7, 64'hFFFF_FFFE, 1'b1, cyc, bc, ovl, q, r, dz);
    n_cmp++;
    if (q !== 64'hFFFF_FFFD || r !== 64'd1 || dz !== 1'b0) begin
      n_bad++; $display("FAIL s_7_m2 got q=%0h r=%0h want fffffffd/1", q, r);
    end
    run_op(32, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, cyc, bc, ovl, q, r, dz);
    n_cmp++;
    if (q !== 64'h8000_0000 || r !== 64'd0 || dz !== 1'b0 || cyc != 33) begin
      n_bad++; $display("FAIL s_ovf got q=%0h r=%0h dz=%0b cyc=%0d want 80000000/0/0/33", q, r, dz, cyc);
    end
`else
    run_op(32, 64'hFFFF_FFF9, 64'd2, 1'b1, cyc, bc, ovl, q, r, dz);
    n_cmp++;
    if (q !== 64'h7FFF_FFFC || r !== 64'd1 || dz !== 1'b0) begin
      n_bad++; $display("FAIL sgn_ignored got q=%0h r=%0h want 7ffffffc/1", q, r);
    end
`endif
  endtask

  task automatic test_ignore_start();
    int cyc;
    a_in = 64'd1000; b_in = 64'd3; sgn = 1'b0; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0; a_in = 64'hDEAD; b_in = 64'd5;
    cyc = 1;
    while (!dn32 && cyc < 100) begin
      st32 = (cyc == 10);
      if (cyc == 10) begin a_in = 64'd9; b_in = 64'd9; end
      @(posedge clk); #1;
      cyc++;
    end
    st32 = 1'b0;
    n_cmp++;
    if (cyc != 33 || q32 !== 32'd333 || r32 !== 32'd1) begin
      n_bad++; $display("FAIL ignore_start got cyc=%0d q=%0d r=%0d want 33/333/1", cyc, q32, r32);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa[3], ob[3], eq[3], er[3];
    int k;
    oa = '{32'd100, 32'd1000, 32'd12345};
    ob = '{32'd7, 32'd10, 32'd67};
    eq = '{32'd14, 32'd100, 32'd184};
    er = '{32'd2, 32'd0, 32'd17};
    k = 0;
    a_in = {32'd0, oa[0]}; b_in = {32'd0, ob[0]}; sgn = 1'b0; st32 = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 99; cyc++) begin
      if (dn32) begin
        n_cmp++;
        if (k > 2 || cyc != 33 * (k + 1) || bz32 !== 1'b0 || q32 !== eq[k % 3] || r32 !== er[k % 3]) begin
          n_bad++;
          $display("FAIL b2b_%0d got cyc=%0d q=%0d r=%0d busy=%0b want cyc=%0d q=%0d r=%0d",
                   k, cyc, q32, r32, bz32, 33 * (k + 1), eq[k % 3], er[k % 3]);
        end
        k++;
        if (k < 3) begin a_in = {32'd0, oa[k]}; b_in = {32'd0, ob[k]}; end
      end
      if (cyc == 99) st32 = 1'b0;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (k != 3) begin
      n_bad++; $display("FAIL b2b_count got %0d done pulses want 3", k);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int cyc, bc, n_done; logic ovl, dz; logic [63:0] q, r;
    a_in = 64'd1000; b_in = 64'd3; sgn = 1'b0; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    for (int c = 1; c < 15; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0; st32 = 1'b1; a_in = 64'd77; b_in = 64'd7;
    @(posedge clk); #1;
    n_cmp++;
    if ({bz32, dn32, q32, r32, dz32} !== '0) begin
      n_bad++; $display("FAIL reset_mid got busy=%0b done=%0b q=%0h r=%0h dz=%0b want all 0",
                        bz32, dn32, q32, r32, dz32);
    end
    rst_n = 1'b1; st32 = 1'b0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (dn32 || bz32) n_done++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (n_done != 0) begin
      n_bad++; $display("FAIL reset_discard got %0d active cycles want 0", n_done);
    end
    run_op(32, 64'd200, 64'd13, 1'b0, cyc, bc, ovl, q, r, dz);
    n_cmp++;
    if (cyc != 33 || q !== 64'd15 || r !== 64'd5 || dz !== 1'b0) begin
      n_bad++; $display("FAIL after_reset got cyc=%0d q=%0d r=%0d want 33/15/5", cyc, q, r);
    end
  endtask

  task automatic test_width8();
    int cyc, bc; logic ovl, dz; logic [63:0] q, r;
    run_op(8, 64'd200, 64'd13, 1'b0, cyc, bc, ovl, q, r, dz);
    n_cmp++;
    if (cyc != 9 || bc != 8 || q !== 64'd15 || r !== 64'd5 || dz !== 1'b0) begin
      n_bad++; $display("FAIL w8_200_13 got cyc=%0d busy=%0d q=%0d r=%0d want 9/8/15/5", cyc, bc, q, r);
    end
  endtask

  task automatic test_random(input int w, input int n);
    int cyc, bc, ecyc; logic ovl, dz, edz, s;
    logic [63:0] a, b, q, r, eq, er;
    for (int i = 0; i < n; i++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0:       b = 64'd0;
        1:       b = 64'($urandom_range(1, 15));
        2:       b = '1;
        3:       b = {$urandom, $urandom} >> $urandom_range(0, 63);
        default: b = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 7) == 0) a = 64'd1 << (w - 1);
      s = 1'($urandom_range(0, 1));
      ref_div(w, a, b, eff_sgn(s), eq, er, edz);
      ecyc = edz ? 1 : w + 1;
      run_op(w, a, b, s, cyc, bc, ovl, q, r, dz);
      n_cmp++;
      if (q !== eq || r !== er || dz !== edz) begin
        n_bad++; $display("FAIL rand_w%0d_%0d a=%0h b=%0h s=%0b got q=%0h r=%0h dz=%0b want q=%0h r=%0h dz=%0b",
                          w, i, a, b, s, q, r, dz, eq, er, edz);
      end
      n_cmp++;
      if (cyc != ecyc || bc != ecyc - 1 || ovl !== 1'b0) begin
        n_bad++; $display("FAIL rand_time_w%0d_%0d got cyc=%0d busy=%0d want cyc=%0d busy=%0d",
                          w, i, cyc, bc, ecyc, ecyc - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    test_random(8, 40);
    test_random(32, 40);
    test_random(64, 30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/div_seq.md
# div_seq

Parametrised multi-cycle integer divider for the FPGA firmware datapath. It computes quotient and remainder one bit per clock using restoring shift-subtract, with a start/busy/done handshake. An optional signed mode is available. It replaces purely combinational division where a 32-step subtract chain does not meet timing, and it serves the control loops that need ratios such as distance/time and duty scaling.

## Interface
Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits (legal range 4..64).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request a division; sampled only when the block is not busy.
- sgn  in  1  1 = signed operands, 0 = unsigned; sampled with start.
- dividend  in  WIDTH  numerator; sampled with start.
- divisor  in  WIDTH  denominator; sampled with start.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse when results become valid.
- quotient  out  WIDTH  result; held until the next accepted start.
- remainder  out  WIDTH  result; held until the next accepted start.
- div_zero  out  1  divisor was 0 for the current result; held with the result.

## Operation
- States: IDLE, CALC, DONE.
- IDLE or DONE with start=1 (accept):
  - Latch operands and sgn.
  - Load the magnitudes into the working registers: a 2*WIDTH partial-remainder/quotient register and a WIDTH divisor register.
  - Clear the step counter and go to CALC.
  - If divisor==0, go straight to DONE instead: quotient = all ones, remainder = dividend, div_zero = 1.
- CALC, each cycle:
  - Shift the working register left by 1.
  - If the upper half is >= the divisor magnitude, subtract it and set bit 0.
  - Increment the counter.
  - After step WIDTH-1, register the final quotient/remainder and go to DONE.
- DONE: done=1 for exactly one cycle. Go to IDLE, or back to CALC if start is accepted in this cycle (back-to-back operation).
- Arithmetic is unsigned magnitude internally. The working compare uses WIDTH+1 bits so no carry is lost at WIDTH=64.
- Signed correction is applied when the result is registered:
  - The quotient is negated if the operand signs differ (truncation toward zero).
  - The remainder takes the sign of the dividend.
- Signed overflow (most-negative / -1): quotient = most-negative value (wraps), remainder = 0, div_zero = 0.
- start while busy (CALC) is ignored: no queueing, and the latched operands are unchanged.
- Operand inputs may change freely after accept.

## Timing
- Accept at edge 0. done is high in cycle WIDTH+1, and busy is high in cycles 1..WIDTH. Latency is 33 cycles at WIDTH=32.
- Divide-by-zero: done is high in cycle 1, and busy never asserts.
- quotient, remainder and div_zero update on the same edge that raises done, and hold until the edge that raises the next done.
- Throughput: one division per WIDTH+1 cycles with start held high.
- Reset (rst_n=0 at an edge, including mid-CALC): state goes to IDLE, and busy, done, div_zero, quotient and remainder all go to 0. The in-flight operation is discarded. start is ignored in the reset cycle.
- busy and done are never high in the same cycle.

## Configuration
- DIV_SIGNED_EN:
  - Defined: sgn is honoured, and the sign correction and overflow logic are built.
  - Undefined: the sgn port remains but is ignored, all operations are unsigned, and the negate/abs logic is not synthesised.
  - Unsigned results are identical in both builds.

## Test plan
- Unsigned, WIDTH=32: 100/7, start at cycle 0 -> done in cycle 33, quotient=14, remainder=2, div_zero=0. Also 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Divide-by-zero: 5/0 -> done in cycle 1, busy never high, quotient=0xFFFFFFFF, remainder=5, div_zero=1.
- Signed (DIV_SIGNED_EN defined, sgn=1):
  - -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
  - 7/-2 -> quotient=-3, remainder=1.
  - 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Handshake:
  - Pulse start again at cycle 10 with different operands -> ignored, and the first result is unchanged.
  - Hold start high -> done pulses in cycles 33, 66, 99.
- Reset mid-op: assert rst_n=0 at cycle 15 -> all outputs 0 next edge, no done pulse. A new start afterwards gives a correct result 33 cycles later.
- Width sweep: WIDTH=8, 200/13 -> done in cycle 9, quotient=15, remainder=5. Also a random-operand comparison against a reference model for WIDTH 8, 32 and 64.
